operand_fetch: RTL
==================

# operand_fetch

Register-file and operand-latch stage feeding the computation stage of the RISC datapath. Holds eight general-purpose registers, selects writeback data from either the external `datapath_in` bus or the computation result `C`, and latches source operands into the `A` and `B` pipeline registers that drive the computation stage's `A`/`B` inputs. All state updates occur on the rising clock edge; register reads are combinational.

## Interface
Parameters:
- `width`, 16, data width of registers, `A`, `B`, `C`, `datapath_in`
- `addrWidth`, 3, register address width; register count is 2**addrWidth (8)

Ports:
- `clk` input 1: rising-edge clock
- `reset` input 1: asynchronous, active-high; clears all state
- `write` input 1: write enable for register file
- `writenum` input addrWidth: destination register index
- `vsel` input 1: writeback select; 0 = `C`, 1 = `datapath_in`
- `datapath_in` input width: external immediate/load data
- `C` input width: result from computation stage
- `readnum` input addrWidth: source register index
- `loada` input 1: capture read data into `A`
- `loadb` input 1: capture read data into `B`
- `data_out` output width: combinational read value of `readnum`
- `A` output width: operand A register, to computation stage
- `B` output width: operand B register, to computation stage

One clock; reset is asynchronous and active-high.

## Operation
- Writeback data `wdata` = `vsel` ? `datapath_in` : `C` (combinational).
- Register file: R0..R7, each `width` bits, no hardwired-zero register. On posedge with `write`=1: R[`writenum`] <= `wdata`. `write`=0: no change.
- `data_out` = R[`readnum`] (see Configuration for same-cycle write).
- On posedge: `loada`=1 → `A` <= `data_out`; `loadb`=1 → `B` <= `data_out`; else hold. Both asserted → both capture the same value.
- All widths are exact; no extension or truncation.
- Any `writenum`/`readnum` value is legal (full decode, no out-of-range case).

## Timing
- Reset (asynchronous assert, immediate): R0..R7 = 0, `A` = 0, `B` = 0; `data_out` = 0 consequently. Deassertion synchronous to `clk` by system design; first write takes effect on the first posedge with `reset`=0.
- Reset mid-write: reset wins; target register is 0 after the edge.
- Write latency: value visible on `data_out` one cycle after the write edge (combinational after the edge).
- Register-to-operand latency: `readnum` set + `loada`/`loadb` → `A`/`B` valid after the next posedge.
- Write and load to same register on same edge: `A`/`B` receive the pre-write value (without bypass).
- Write and read of different registers on same edge: independent.

## Configuration
- `OPERAND_FETCH_BYPASS_EN` defined: when `write`=1 and `writenum`==`readnum`, `data_out` = `wdata` (write-through forwarding); `A`/`B` loading on that edge capture the new value. Register contents unchanged from base behaviour.
- Undefined: `data_out` always the stored register value; same-edge write/load yields the old value.

## Structure
- Shared package: default `width`/`addrWidth`, register count constant, `vsel` encodings (`VSEL_C`=0, `VSEL_DIN`=1).
- Sub-module `regfile`: the 8-entry array, write decoder, and read mux (plus bypass under the macro). `operand_fetch` instantiates it and adds the writeback mux and the `A`/`B` load registers.

## Test plan
- Reset: assert `reset` with garbage in all regs → R0..R7, `A`, `B`, `data_out` all 0 immediately, before any clock edge.
- Load/operand: `vsel`=1, write 46 to R1, 29 to R2; then `readnum`=1 `loada`=1, next cycle `readnum`=2 `loadb`=1 → `A`=46, `B`=29 (computation stage then yields 60 with `shift`=10, `ALUop`=00).
- Writeback from C: `C`=60, `vsel`=0, `write`=1, `writenum`=3 → after edge, `readnum`=3 gives `data_out`=60; `datapath_in` ignored.
- Hold: `loada`=`loadb`=0 for 4 cycles while writing R1 = 0xFFFF → `A`/`B` unchanged (46/29).
- Same-edge hazard: R4=5; write 9 to R4 with `readnum`=4 `loada`=1 same edge → `A`=5 without `OPERAND_FETCH_BYPASS_EN`, `A`=9 with it; R4=9 in both.
- Reset mid-operation: `reset` pulse between posedges during a write of 0x1234 to R7 → R7=0, `A`=`B`=0, next write succeeds normally.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// ============================================================================
//  Module   : operand_fetch_pkg
//  Purpose  : Shared defaults and writeback-select encodings for operand_fetch.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package operand_fetch_pkg;

   localparam int DEFAULT_WIDTH      = 16;
   localparam int DEFAULT_ADDR_WIDTH = 3;
   localparam int NUM_REGS           = 2 ** DEFAULT_ADDR_WIDTH;

   localparam logic VSEL_C   = 1'b0;
   localparam logic VSEL_DIN = 1'b1;

endpackage : operand_fetch_pkg

`default_nettype wire

// File: rtl/operand_fetch_regfile.sv
// ============================================================================
//  Module   : operand_fetch_regfile
//  Purpose  : General-purpose register array with decoded write and
//             combinational read; OPERAND_FETCH_BYPASS_EN adds write-through.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch_regfile
   import operand_fetch_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_write,
   input  logic [ADDR_WIDTH-1:0] i_writenum,
   input  logic [WIDTH-1:0]      i_wdata,
   input  logic [ADDR_WIDTH-1:0] i_readnum,
   output logic [WIDTH-1:0]      o_data_out
);

   localparam int c_depth = 2 ** ADDR_WIDTH;

   logic [WIDTH-1:0] r_regs [c_depth];
   logic [c_depth-1:0] w_we;
   logic [WIDTH-1:0] w_stored;

   generate
      for (genvar gi = 0; gi < c_depth; gi++) begin : g_dec
         assign w_we[gi] = i_write && (i_writenum == ADDR_WIDTH'(gi));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < c_depth; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < c_depth; i++) begin
            if (w_we[i]) begin
               r_regs[i] <= i_wdata;
            end
         end
      end
   end

   assign w_stored = r_regs[i_readnum];

`ifdef OPERAND_FETCH_BYPASS_EN
   // Forward the in-flight write so a same-edge load sees the new value.
   logic w_hit;
   assign w_hit      = i_write && (i_writenum == i_readnum);
   assign o_data_out = w_hit ? i_wdata : w_stored;
`else
   assign o_data_out = w_stored;
`endif

endmodule : operand_fetch_regfile

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
//  Module   : operand_fetch
//  Purpose  : Register file, writeback select and A/B operand latches feeding
//             the computation stage. Optional macro: OPERAND_FETCH_BYPASS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch
   import operand_fetch_pkg::*;
#(
   parameter int width     = DEFAULT_WIDTH,
   parameter int addrWidth = DEFAULT_ADDR_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 write,
   input  logic [addrWidth-1:0] writenum,
   input  logic                 vsel,
   input  logic [width-1:0]     datapath_in,
   input  logic [width-1:0]     C,
   input  logic [addrWidth-1:0] readnum,
   input  logic                 loada,
   input  logic                 loadb,
   output logic [width-1:0]     data_out,
   output logic [width-1:0]     A,
   output logic [width-1:0]     B
);

   logic [width-1:0] w_wdata;
   logic [width-1:0] w_data_out;
   logic [width-1:0] r_a;
   logic [width-1:0] r_b;

   assign w_wdata = (vsel == VSEL_DIN) ? datapath_in : C;

   operand_fetch_regfile #(
      .WIDTH      (width),
      .ADDR_WIDTH (addrWidth)
   ) u_regfile (
      .clk        (clk),
      .rst        (reset),
      .i_write    (write),
      .i_writenum (writenum),
      .i_wdata    (w_wdata),
      .i_readnum  (readnum),
      .o_data_out (w_data_out)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a <= '0;
         r_b <= '0;
      end else begin
         if (loada) begin
            r_a <= w_data_out;
         end
         if (loadb) begin
            r_b <= w_data_out;
         end
      end
   end

   assign data_out = w_data_out;
   assign A        = r_a;
   assign B        = r_b;

endmodule : operand_fetch

`default_nettype wire
